// File: rtl/inst_mem_loader.sv
// Byte-stream loader for the CPU instruction RAM: packs 4 big-endian bytes per word,
// writes consecutive word addresses from 0 and holds the CPU while loading.
module inst_mem_loader #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold
);

  localparam int unsigned CW  = AW + 1;
  localparam logic [AW:0] CAP = CW'(2 ** AW);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t        state;
  logic [AW:0]   count;
  logic [1:0]    bcnt;
  logic [AW-1:0] addr;
  logic [23:0]   shift;

  logic [AW:0]   len_sat_c;
  logic          last_c;

  // Requested length clamps to memory capacity; last word when address reaches count-1.
  assign len_sat_c = (len > CAP) ? CAP : len;
  assign last_c    = ({1'b0, addr} == (count - CW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      bcnt     <= '0;
      addr     <= '0;
      shift    <= '0;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_d    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      case (state)
        // IDLE and DONE accept a new load identically; done stays sticky until then.
        IDLE, DONE: begin
          if (start) begin
            count <= len_sat_c;
            if (len_sat_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RECV;
              bcnt     <= '0;
              addr     <= '0;
              shift    <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
              done     <= 1'b0;
            end
          end
        end

        // in_ready is 1 throughout RECV, so in_valid alone marks an accepted byte.
        RECV: begin
          if (in_valid) begin
            shift <= {shift[15:0], in_data};
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              mem_we   <= 1'b1;
              mem_a    <= addr;
              mem_d    <= DW'({shift, in_data});
            end
          end
        end

        WRITE: begin
          mem_we <= 1'b0;
          if (last_c) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            state    <= RECV;
            addr     <= addr + AW'(1);
            in_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side counterpart of the CPU's instruction memory.
- Accepts a byte stream, for example from a UART receiver or a debug port.
- Assembles each group of 4 bytes, big-endian, into one 32-bit instruction and writes it into the instruction RAM at consecutive word addresses starting from 0.
- Holds the CPU in reset/stall (`cpu_hold`) while a load is in progress and flags completion.

Parameters:
- AW, 6, instruction memory word-address width; capacity is 2**AW words (64).
- DW, 32, instruction width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load.
- len  in  AW+1  number of words to load, sampled on an accepted start.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction RAM write enable.
- mem_a  out  AW  instruction RAM word address.
- mem_d  out  DW  instruction RAM write data.
- busy  out  1  load in progress.
- done  out  1  last load completed.
- cpu_hold  out  1  stall/hold the CPU.

Behaviour:
- Reset is asynchronous, active-high. While rst=1 and after it releases:
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_a=0, mem_d=0.
  - busy=0, done=0, cpu_hold=0.
  - byte counter=0, word address=0.
- Reset asserted mid-load aborts immediately. RAM words already written stay as they are, and no further write occurs.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start=1 latches the target word count. If len > 2**AW the count saturates to 2**AW.
  - With a nonzero count, start clears the byte counter and word address and moves to RECV.
  - start with len=0 moves directly to DONE and performs no write.
- RECV:
  - in_ready=1 and busy=1.
  - A byte is accepted when in_valid and in_ready are both 1 on a clock edge. On acceptance: shift register <= {shift[23:0], in_data}, and the byte counter increments (2-bit, wraps).
  - The first byte of a word lands in bits 31:24.
  - Accepting the 4th byte moves to WRITE.
  - in_valid=0 simply stalls; no timeout.
- WRITE, exactly 1 cycle:
  - mem_we=1, mem_a=word address, mem_d=assembled word.
  - in_ready=0, so no byte is accepted in this cycle.
  - Next cycle: if word address == count-1, go to DONE; otherwise increment the word address and go back to RECV.
  - mem_a never wraps within a load.
- DONE:
  - done=1 (sticky), busy=0, cpu_hold=0, in_ready=0.
  - start=1 begins a new load with the same rules as in IDLE, and clears done on the transition.
- busy = cpu_hold = 1 exactly when state is RECV or WRITE.
- start is ignored while busy.
- mem_we is 0 in every state except WRITE.
- mem_a and mem_d may hold their last values when mem_we=0.
- Latency and throughput:
  - Minimum 5 cycles per word: 4 accept cycles plus 1 write cycle.
  - done rises in the cycle after the final WRITE cycle.
- All outputs are registered or decoded from state only. There are no combinational paths from in_valid or start to any output.

Test Plan:
1. Normal 2-word load.
   - Stimulus: rst pulse; start with len=2; stream 00 10 04 43 04 10 10 25 with in_valid held high.
   - Required: mem_we pulse with a=0, d=0x00100443, then a=1, d=0x04101025; 10 cycles from the first accept to done=1; busy and cpu_hold high throughout and low after.
2. Backpressure gaps.
   - Stimulus: same stream as scenario 1, in_valid toggled randomly.
   - Required: identical writes; no byte is lost or duplicated; in_ready=0 during each WRITE cycle.
3. len=0.
   - Stimulus: start with len=0.
   - Required: no mem_we; done=1 one cycle later; busy never asserts.
4. Saturation.
   - Stimulus: start with len=100; stream 280 bytes.
   - Required: exactly 64 writes to a=0..63 with data equal to the byte-assembled words; done asserted after the write at a=63; in_ready=0 afterwards, so the remaining 24 bytes are not accepted.
5. Reset mid-word.
   - Stimulus: after 2 bytes of word 1 (word 0 already written), assert rst asynchronously between clock edges.
   - Required: outputs go to reset values immediately; no mem_we; a subsequent start with len=1 followed by bytes DE AD BE EF writes a=0, d=0xDEADBEEF (no stale partial bytes).
6. start while busy.
   - Stimulus: pulse start with len=5 midway through a len=2 load.
   - Required: ignored; only 2 words are written; done asserts normally. A start after done begins a new load and clears done.
